// File: rtl/lsfr_seq_checker.sv
// Self-synchronising checker for a Galois LFSR stream: seeds a predictor from the
// incoming words, locks after a run of correct predictions, then counts mismatches.
module lsfr_seq_checker #(
    parameter int unsigned           BIT_WIDTH = 8,
    parameter logic [BIT_WIDTH-1:0]  POLY      = BIT_WIDTH'(8'hB8),
    parameter int unsigned           LOCK_CNT  = 4,
    parameter int unsigned           LOSS_CNT  = 3,
    parameter int unsigned           CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_done,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 sync_loss,
    output logic                 chk_done,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     word_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        CHECK
    } state_t;

    localparam logic [8:0] LOCK_LIM = 9'(LOCK_CNT);
    localparam logic [8:0] LOSS_LIM = 9'(LOSS_CNT);

    function automatic logic [BIT_WIDTH-1:0] step(input logic [BIT_WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? POLY : '0);
    endfunction

    state_t               state_q, state_d;
    logic [BIT_WIDTH-1:0] exp_q, exp_d;
    logic [7:0]           match_q, match_d;
    logic [7:0]           miss_q, miss_d;
    logic                 done_pend_q, done_pend_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 sync_loss_q, sync_loss_d;
    logic                 chk_done_q, chk_done_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic                 count_err, count_word;
    logic [8:0]           match_inc, miss_inc;

    assign match_inc = {1'b0, match_q} + 9'd1;
    assign miss_inc  = {1'b0, miss_q} + 9'd1;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        match_d     = match_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        done_pend_d = 1'b0;
        err_pulse_d = 1'b0;
        sync_loss_d = 1'b0;
        chk_done_d  = 1'b0;
        count_err   = 1'b0;
        count_word  = 1'b0;

        // The cycle after a done word is reserved for the forced exit; any word on it is dropped.
        if (done_pend_q) begin
            state_d    = IDLE;
            locked_d   = 1'b0;
            chk_done_d = 1'b1;
        end else if (in_vld) begin
            done_pend_d = in_done;
            unique case (state_q)
                IDLE: begin
                    if (in_data != '0) begin
                        exp_d   = step(in_data);
                        match_d = '0;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    exp_d = step(in_data);
                    if (in_data == exp_q) begin
                        match_d = match_inc[7:0];
                        if (match_inc == LOCK_LIM) begin
                            state_d  = CHECK;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else begin
                        match_d = '0;
                        if (in_data == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
                CHECK: begin
                    exp_d      = step(exp_q);
                    count_word = 1'b1;
                    if (in_data != exp_q) begin
                        err_pulse_d = 1'b1;
                        count_err   = 1'b1;
                        miss_d      = miss_inc[7:0];
                        if (miss_inc == LOSS_LIM) begin
                            state_d     = LOCK;
                            locked_d    = 1'b0;
                            sync_loss_d = 1'b1;
                            exp_d       = step(in_data);
                            match_d     = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        err_cnt_d  = err_cnt_q;
        word_cnt_d = word_cnt_q;
        if (clr) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end else begin
            if (count_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (count_word && (word_cnt_q != '1)) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            done_pend_q <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            sync_loss_q <= 1'b0;
            chk_done_q  <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            done_pend_q <= done_pend_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            sync_loss_q <= sync_loss_d;
            chk_done_q  <= chk_done_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign sync_loss = sync_loss_q;
    assign chk_done  = chk_done_q;
    assign err_cnt   = err_cnt_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_lsfr_seq_checker.sv
// Directed bench for lsfr_seq_checker: a cycle-level reference model is compared
// against two instances (16-bit and 4-bit counters) every cycle, plus literal pins.
module tb_lsfr_seq_checker;

    logic       clk = 1'b0;
    logic       rst, in_vld, in_done, clr;
    logic [7:0] in_data;

    logic        locked, err_pulse, sync_loss, chk_done;
    logic [15:0] err_cnt, word_cnt;
    logic        s_locked, s_err_pulse, s_sync_loss, s_chk_done;
    logic [3:0]  s_err_cnt, s_word_cnt;

    always #5 clk = ~clk;

    lsfr_seq_checker u_dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_done(in_done), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .sync_loss(sync_loss), .chk_done(chk_done),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    lsfr_seq_checker #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_done(in_done), .clr(clr),
        .locked(s_locked), .err_pulse(s_err_pulse), .sync_loss(s_sync_loss), .chk_done(s_chk_done),
        .err_cnt(s_err_cnt), .word_cnt(s_word_cnt)
    );

    int nchk = 0;
    int nerr = 0;
    int x;

    // Reference model state: mode 0 = hunting, 1 = acquiring, 2 = tracking.
    int m_mode, m_exp, m_run, m_miss;
    bit m_pend;
    bit e_locked, e_err, e_loss, e_done;
    int e_ec, e_wc, e_ec4, e_wc4;

    function automatic int nxt(int v);
        return (v >> 1) ^ (((v & 1) != 0) ? 'hB8 : 0);
    endfunction

    function automatic int sat_inc(int v, int maxv);
        return (v < maxv) ? v + 1 : maxv;
    endfunction

    task automatic check(string name, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pend_n, add_e, add_w;
        int d;
        d = int'(in_data);
        if (rst) begin
            m_mode = 0; m_exp = 0; m_run = 0; m_miss = 0; m_pend = 0;
            e_locked = 0; e_err = 0; e_loss = 0; e_done = 0;
            e_ec = 0; e_wc = 0; e_ec4 = 0; e_wc4 = 0;
            return;
        end
        e_err = 0; e_loss = 0; e_done = 0; pend_n = 0; add_e = 0; add_w = 0;
        if (m_pend) begin
            m_mode = 0; e_locked = 0; e_done = 1;
        end else if (in_vld) begin
            pend_n = in_done;
            if (m_mode == 0) begin
                if (d != 0) begin m_exp = nxt(d); m_run = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == m_exp) begin
                    m_run++;
                    if (m_run == 4) begin m_mode = 2; e_locked = 1; m_miss = 0; end
                end else begin
                    m_run = 0;
                    if (d == 0) m_mode = 0;
                end
                if (m_mode != 0 || d != 0) m_exp = nxt(d);
            end else begin
                add_w = 1;
                if (d != m_exp) begin
                    e_err = 1; add_e = 1; m_miss++;
                end else begin
                    m_miss = 0;
                end
                m_exp = nxt(m_exp);
                if (m_miss == 3) begin
                    m_mode = 1; e_locked = 0; e_loss = 1; m_exp = nxt(d); m_run = 0;
                end
            end
        end
        m_pend = pend_n;
        if (clr) begin
            e_ec = 0; e_wc = 0; e_ec4 = 0; e_wc4 = 0;
        end else begin
            if (add_e) begin e_ec = sat_inc(e_ec, 65535); e_ec4 = sat_inc(e_ec4, 15); end
            if (add_w) begin e_wc = sat_inc(e_wc, 65535); e_wc4 = sat_inc(e_wc4, 15); end
        end
    endtask

    task automatic compare_all();
        check("locked",     int'(locked),     int'(e_locked));
        check("err_pulse",  int'(err_pulse),  int'(e_err));
        check("sync_loss",  int'(sync_loss),  int'(e_loss));
        check("chk_done",   int'(chk_done),   int'(e_done));
        check("err_cnt",    int'(err_cnt),    e_ec);
        check("word_cnt",   int'(word_cnt),   e_wc);
        check("sat_locked", int'(s_locked),   int'(e_locked));
        check("sat_err",    int'(s_err_cnt),  e_ec4);
        check("sat_word",   int'(s_word_cnt), e_wc4);
    endtask

    task automatic cyc(bit r, bit v, int d, bit dn, bit c);
        rst = r; in_vld = v; in_data = 8'(d); in_done = dn; clr = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic word(int d, bit dn = 1'b0, bit c = 1'b0);
        cyc(1'b0, 1'b1, d, dn, c);
    endtask

    task automatic gap();
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic send_run(int n);
        for (int i = 0; i < n; i++) begin
            word(x);
            x = nxt(x);
        end
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_data = '0; in_done = 1'b0; clr = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err_cnt", int'(err_cnt), 0);

        // zero words are ignored while hunting
        repeat (3) word(0);
        check("idle_zero", int'(locked), 0);

        // lock on 01 B8 5C 2E 17, then B3 is the first tracked word
        x = 'h01;
        send_run(4);
        check("lock_early", int'(locked), 0);
        check("seq_2e_next", x, 'h17);
        send_run(1);
        check("lock_on_17", int'(locked), 1);
        send_run(1);
        check("lock_b3", int'(locked), 1);
        check("lock_err0", int'(err_cnt), 0);
        check("lock_wc1", int'(word_cnt), 1);

        // single corrupted word
        send_run(3);
        word(x ^ 1);
        x = nxt(x);
        check("single_pulse", int'(err_pulse), 1);
        check("single_cnt", int'(err_cnt), 1);
        send_run(4);
        check("single_after", int'(err_cnt), 1);
        check("single_locked", int'(locked), 1);

        // loss of lock after three misses, then re-acquire from an arbitrary seed
        cyc(0, 0, 0, 0, 1);
        check("clr_idle", int'(err_cnt), 0);
        repeat (2) begin word(x ^ 'h55); x = nxt(x); end
        check("loss_hold", int'(locked), 1);
        word(0);
        check("loss_pulse", int'(sync_loss), 1);
        check("loss_locked", int'(locked), 0);
        check("loss_cnt", int'(err_cnt), 3);
        x = 'h42;
        send_run(4);
        check("relock_early", int'(locked), 0);
        send_run(1);
        check("relock", int'(locked), 1);

        // gapped stream with done on word 10
        cyc(1, 0, 0, 0, 0);
        check("rst2_wc", int'(word_cnt), 0);
        x = 'h01;
        for (int i = 1; i <= 10; i++) begin
            word(x, i == 10);
            x = nxt(x);
            if (i < 10) gap();
        end
        check("gap_wc5", int'(word_cnt), 5);
        check("gap_err0", int'(err_cnt), 0);
        gap();
        check("gap_done", int'(chk_done), 1);
        check("gap_unlock", int'(locked), 0);
        gap();
        check("gap_done_off", int'(chk_done), 0);

        // clr coincident with a mismatch
        x = 'h01;
        send_run(5);
        check("clr_lock", int'(locked), 1);
        word(x ^ 2, 1'b0, 1'b1);
        x = nxt(x);
        check("clr_pulse", int'(err_pulse), 1);
        check("clr_cnt", int'(err_cnt), 0);

        // 20 isolated misses: 4-bit counter pins at 15
        for (int i = 0; i < 20; i++) begin
            word(x ^ 4); x = nxt(x);
            word(x);     x = nxt(x);
        end
        check("sat_15", int'(s_err_cnt), 15);
        check("sat_20", int'(err_cnt), 20);
        check("sat_locked", int'(locked), 1);

        // done on the word that drops lock
        word(0); x = nxt(x);
        word(0); x = nxt(x);
        word(0, 1'b1);
        check("dloss_pulse", int'(sync_loss), 1);
        gap();
        check("dloss_done", int'(chk_done), 1);
        check("dloss_pulse_off", int'(sync_loss), 0);

        // done on the word that completes lock
        x = 'h5A;
        send_run(4);
        word(x, 1'b1);
        x = nxt(x);
        check("dlock_high", int'(locked), 1);
        gap();
        check("dlock_low", int'(locked), 0);
        check("dlock_done", int'(chk_done), 1);

        // reset while tracking, with a valid word present
        x = 'h01;
        send_run(7);
        check("mid_locked", int'(locked), 1);
        cyc(1, 1, x, 0, 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_wc", int'(word_cnt), 0);
        x = 'h01;
        send_run(5);
        check("mid_relock", int'(locked), 1);
        gap();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
